aes_round_sequencer: RTL
========================

Name: aes_round_sequencer

Overview:
Control-only sequencer for a shared iterative AES-128 round datapath and its round-key store. It accepts one encrypt or decrypt request at a time, runs key expansion when a new key is flagged, and then steps the datapath through the initial AddRoundKey, the middle rounds and the final round. It holds the result-valid handshake until the consumer takes it. It sits between the transactor's input/output pipe logic and the AES round/key-schedule datapath and carries no data itself.

Parameters:
NUM_ROUNDS, 10, number of AES rounds (10 for AES-128); legal range 2..14.
IDX_W, 4, width of round/key index outputs; must hold NUM_ROUNDS.
CNT_W, 16, width of the completed-operation counter.

Ports:
clock  in  1  system clock, all state on posedge.
reset  in  1  asynchronous, active-high; state to IDLE immediately.
req_valid  in  1  request present; data and key are held stable on the datapath inputs by the requester.
req_ready  out  1  request accepted when req_valid && req_ready.
req_decrypt  in  1  0 = encrypt, 1 = decrypt; sampled at accept.
req_new_key  in  1  key changed; force expansion; sampled at accept.
rsp_valid  out  1  datapath state register holds the result.
rsp_ready  in  1  consumer takes the result.
ks_load  out  1  key schedule loads the cipher key as round key 0.
ks_step  out  1  key schedule computes and stores round key ks_idx.
ks_idx  out  IDX_W  round-key index being written.
dp_load  out  1  state register gets input XOR round key dp_idx.
dp_round_en  out  1  perform a full round with round key dp_idx.
dp_final  out  1  perform the final round (no MixColumns) with round key dp_idx.
dp_decrypt  out  1  latched mode; drives the inverse datapath.
dp_idx  out  IDX_W  round-key index for the datapath this cycle.
busy  out  1  high in every state except IDLE.
op_count  out  CNT_W  completed operations; wraps to 0 after all-ones.

Behaviour:
- Reset values: req_ready=0 while reset is high. Every other output is 0. key_valid (internal) is 0. State is IDLE. op_count is 0.
- States: IDLE, KEYEXP, LOAD, ROUND, FINAL, DONE.
- IDLE: req_ready=1 (when reset is low).
  - On accept, latch req_decrypt into dp_decrypt.
  - Go to KEYEXP if req_new_key or !key_valid; otherwise go to LOAD.
- KEYEXP: lasts 1+NUM_ROUNDS cycles.
  - Cycle 0: ks_load=1, ks_idx=0.
  - Cycles k=1..NUM_ROUNDS: ks_step=1, ks_idx=k.
  - Then set key_valid=1 and go to LOAD.
- LOAD: 1 cycle. dp_load=1. dp_idx=0 for encrypt, NUM_ROUNDS for decrypt.
- ROUND: NUM_ROUNDS-1 cycles with dp_round_en=1.
  - Encrypt: dp_idx counts 1 up to NUM_ROUNDS-1.
  - Decrypt: dp_idx counts NUM_ROUNDS-1 down to 1.
- FINAL: 1 cycle. dp_final=1. dp_idx=NUM_ROUNDS for encrypt, 0 for decrypt.
- DONE: rsp_valid=1, held until rsp_ready is sampled high.
  - That cycle: op_count increments and state goes to IDLE.
  - rsp_valid drops the next cycle.
  - A new request can be accepted no earlier than the cycle after the handshake; there is no back-to-back overlap.
- Latency, accept in cycle T with rsp_ready tied high: rsp_valid rises at T+NUM_ROUNDS+2 (T+12 at default). With expansion: T+2*NUM_ROUNDS+3 (T+23 at default).
- Strobe exclusivity:
  - At most one of ks_load/ks_step/dp_load/dp_round_en/dp_final is high in any cycle.
  - All are 0 in IDLE and DONE.
  - ks_idx and dp_idx read 0 whenever their strobes are low.
- req_decrypt and req_new_key are ignored outside the accept cycle.
- req_valid while busy has no effect; the request waits.
- rsp_ready while not in DONE is ignored.
- key_valid persists across requests. Only reset or req_new_key forces re-expansion.
- Reset asserted mid-operation (any state): immediate return to IDLE with all outputs 0. key_valid is cleared, so the next request always expands. op_count is cleared.
- op_count wraps from 2^CNT_W-1 to 0 without a flag.

Test Plan:
- Reset then encrypt, req_new_key=0: key_valid=0 forces KEYEXP. ks_load at T+1, ks_step idx 1..10 at T+2..T+11. dp_load idx0 at T+12, dp_round_en idx1..9 at T+13..T+21, dp_final idx10 at T+22. rsp_valid at T+23. op_count=1.
- Second encrypt, same key, req_new_key=0: no ks strobes. dp_load at T+1. rsp_valid at T+12.
- Decrypt, same key: dp_load idx10, rounds idx 9..1, dp_final idx0. dp_decrypt=1 throughout. rsp_valid at T+12.
- rsp_ready held low for 5 cycles in DONE: rsp_valid stays high and req_ready stays 0. req_valid is pending. Handshake on cycle 6; req_ready goes high the following cycle. op_count increments exactly once.
- Reset pulsed during ROUND (dp_idx=5): all strobes 0 at once. Next request with req_new_key=0 still runs KEYEXP (rsp_valid at T+23). op_count=0 before it completes.
- Preload op_count to 0xFFFF via 65535 operations (or force): the next completion gives 0x0000.

Source files
------------

// File: rtl/aes_round_sequencer_if.sv
// Request/response handshake plus key-schedule and round-datapath control strobes.
// Latency: none, wires only.
// Backpressure: req_valid/req_ready on the request side, rsp_valid/rsp_ready on the result side.
interface aes_round_sequencer_if #(
   parameter int IDX_W = 4,
   parameter int CNT_W = 16
);
   logic             req_valid;
   logic             req_ready;
   logic             req_decrypt;
   logic             req_new_key;
   logic             rsp_valid;
   logic             rsp_ready;
   logic             ks_load;
   logic             ks_step;
   logic [IDX_W-1:0] ks_idx;
   logic             dp_load;
   logic             dp_round_en;
   logic             dp_final;
   logic             dp_decrypt;
   logic [IDX_W-1:0] dp_idx;
   logic             busy;
   logic [CNT_W-1:0] op_count;

   // Requester / consumer / datapath side
   modport master (
      output req_valid, req_decrypt, req_new_key, rsp_ready,
      input  req_ready, rsp_valid, ks_load, ks_step, ks_idx,
             dp_load, dp_round_en, dp_final, dp_decrypt, dp_idx, busy, op_count
   );

   // Sequencer side
   modport slave (
      input  req_valid, req_decrypt, req_new_key, rsp_ready,
      output req_ready, rsp_valid, ks_load, ks_step, ks_idx,
             dp_load, dp_round_en, dp_final, dp_decrypt, dp_idx, busy, op_count
   );
endinterface

// File: rtl/aes_round_sequencer.sv
// Control sequencer for an iterative AES round datapath and its round-key store.
// Latency: accept to rsp_valid is NUM_ROUNDS+2 cycles, plus NUM_ROUNDS+1 when the key is expanded.
// Backpressure: one operation in flight; result held in DONE until rsp_ready, req_ready only in IDLE.
module aes_round_sequencer #(
   parameter int NUM_ROUNDS = 10,
   parameter int IDX_W      = 4,
   parameter int CNT_W      = 16
) (
   input logic                   clock,
   input logic                   reset,
   aes_round_sequencer_if.slave  bus
);

   typedef enum logic [2:0] {IDLE, KEYEXP, LOAD, ROUND, FINAL, DONE} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);
   localparam logic [IDX_W-1:0] LAST_MID = IDX_W'(NUM_ROUNDS - 1);
   localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic             dec_q, dec_d;
   logic             key_valid_q, key_valid_d;
   logic [CNT_W-1:0] op_count_q, op_count_d;

   logic             req_ready;
   logic             rsp_valid;
   logic             ks_load;
   logic             ks_step;
   logic [IDX_W-1:0] ks_idx;
   logic             dp_load;
   logic             dp_round_en;
   logic             dp_final;
   logic [IDX_W-1:0] dp_idx;

   // State, step counter, latched mode, key-valid flag and completion counter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         dec_q       <= 1'b0;
         key_valid_q <= 1'b0;
         op_count_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dec_q       <= dec_d;
         key_valid_q <= key_valid_d;
         op_count_q  <= op_count_d;
      end
   end

   // Next-state and strobe decode; indices read 0 whenever their strobe is idle.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dec_d       = dec_q;
      key_valid_d = key_valid_q;
      op_count_d  = op_count_q;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      ks_load     = 1'b0;
      ks_step     = 1'b0;
      ks_idx      = '0;
      dp_load     = 1'b0;
      dp_round_en = 1'b0;
      dp_final    = 1'b0;
      dp_idx      = '0;
      case (state_q)
         IDLE: begin
            req_ready = !reset;
            if (bus.req_valid) begin
               dec_d   = bus.req_decrypt;
               cnt_d   = '0;
               state_d = (bus.req_new_key || !key_valid_q) ? KEYEXP : LOAD;
            end
         end
         KEYEXP: begin
            ks_idx = cnt_q;
            if (cnt_q == '0) ks_load = 1'b1;
            else             ks_step = 1'b1;
            if (cnt_q == LAST_IDX) begin
               key_valid_d = 1'b1;
               cnt_d       = '0;
               state_d     = LOAD;
            end else begin
               cnt_d = cnt_q + ONE_IDX;
            end
         end
         LOAD: begin
            dp_load = 1'b1;
            dp_idx  = dec_q ? LAST_IDX : '0;
            cnt_d   = ONE_IDX;
            state_d = ROUND;
         end
         ROUND: begin
            // cnt_q walks 1..NUM_ROUNDS-1; decrypt mirrors it to walk the keys downwards.
            dp_round_en = 1'b1;
            dp_idx      = dec_q ? (LAST_IDX - cnt_q) : cnt_q;
            if (cnt_q == LAST_MID) state_d = FINAL;
            else                   cnt_d   = cnt_q + ONE_IDX;
         end
         FINAL: begin
            dp_final = 1'b1;
            dp_idx   = dec_q ? '0 : LAST_IDX;
            cnt_d    = '0;
            state_d  = DONE;
         end
         DONE: begin
            rsp_valid = 1'b1;
            if (bus.rsp_ready) begin
               op_count_d = op_count_q + CNT_W'(1);
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.req_ready   = req_ready;
   assign bus.rsp_valid   = rsp_valid;
   assign bus.ks_load     = ks_load;
   assign bus.ks_step     = ks_step;
   assign bus.ks_idx      = ks_idx;
   assign bus.dp_load     = dp_load;
   assign bus.dp_round_en = dp_round_en;
   assign bus.dp_final    = dp_final;
   assign bus.dp_idx      = dp_idx;
   assign bus.dp_decrypt  = dec_q;
   assign bus.busy        = (state_q != IDLE);
   assign bus.op_count    = op_count_q;

endmodule
